dtw_dist_router: RTL and testbench
==================================

Name: dtw_dist_router

Overview:
- Parametrised distance-routing stage for the DTW systolic array.
- Each wavefront it accepts the NPE-lane distance vector from the array and keeps a DIAG_AGE-deep history of accepted wavefronts.
- Drives per-PE diagonal (D0), vertical (D1) and horizontal (D2) operands, selected by per-PE codes.
- Adds valid qualification, a wavefront counter and a sticky select-error flag.

Parameters:
- NPE, 6: number of processing elements/lanes.
- DW, 16: distance width per lane.
- SELW, 3: per-PE select code width; must satisfy 2^SELW >= NPE+2.
- DIAG_AGE, 1: accepted-wavefront delay applied to the D0 source; legal range 1..4.
- CNTW, 10: wavefront counter width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low clears history.
- i_start  in  1  synchronous start of new alignment; clears history, counter and error flag.
- i_valid  in  1  i_d carries a valid wavefront.
- i_d  in  NPE*DW  current array distances; lane 0 in the MSBs.
- i_sel0  in  NPE*SELW  D0 select codes; PE 0 in the MSBs.
- i_sel1  in  NPE*SELW  D1 select codes.
- i_sel2  in  NPE*SELW  D2 select codes.
- o_d0  out  NPE*DW  diagonal operands.
- o_d1  out  NPE*DW  vertical operands.
- o_d2  out  NPE*DW  horizontal operands.
- o_valid  out  1  o_d0/o_d1/o_d2 valid.
- o_wave  out  CNTW  accepted wavefronts since last start, saturating.
- o_sel_err  out  1  sticky: a reserved select code was used on an accepted wavefront.

Behaviour:
- Accept condition: acc = ena & i_valid.
- History: hist[0..DIAG_AGE-1], each NPE*DW wide.
  - On acc: hist[0] <= i_d and hist[k] <= hist[k-1].
  - No acc with ena high: hold.
  - ena low: all hist cleared to 0, takes priority over everything except reset.
- Select decode, identical for every PE p and every operand:
  - code c < NPE: lane c of the source vector.
  - code NPE .. 2^SELW-2: INF, all ones at DW bits.
  - code 2^SELW-1: zero.
- Sources:
  - D0 reads hist[DIAG_AGE-1].
  - D1 and D2 read the live i_d.
- Outputs without the optional feature:
  - o_d0/o_d1/o_d2 are combinational from i_d, hist and the selects.
  - o_valid = acc combinationally; latency 0.
- i_start, when ena is high:
  - hist cleared to 0, o_wave <= 0, o_sel_err <= 0.
  - If acc is also high in the same cycle, hist[0] <= i_d and o_wave <= 1 (start-with-data). The error check applies to that wavefront.
- o_wave: increments on acc and saturates at 2^CNTW-1; unchanged when ena is low.
- o_sel_err:
  - Set on acc if any of the 3*NPE codes lies in the INF range.
  - Cleared only by i_start or reset.
  - The zero code is never an error.
- Reset (nrst low, asynchronous): hist = 0, o_wave = 0, o_sel_err = 0.
  - Combinational outputs then follow their inputs, so o_d0 equals the decode of zero history.
  - o_valid follows acc.
- Mid-operation ena drop: history is lost; the next accepted wavefront sees D0 = 0 for DIAG_AGE wavefronts.
- The counter is kept, so the controller must reissue i_start to realign.

Optional Feature:
- Macro: DTW_ROUTE_OREG_EN.
- When defined:
  - o_d0/o_d1/o_d2 and o_valid are registered: latency 1 cycle.
  - o_valid <= acc, reset value 0; data registers reset to 0.
  - Data registers load only when acc is high and otherwise hold.
  - ena low forces o_valid <= 0.
  - History and error behaviour are unchanged.
- When undefined: outputs are combinational as above; latency 0.

Test Plan:
- Reset with defaults, nrst released, ena=1, i_valid=0 -> o_wave=0, o_sel_err=0, o_valid=0, o_d0 lanes = 0 for sel0 codes 0..5.
- Two accepted wavefronts: lane k of the first = 0x0100+k, lane k of the second = 0x0200+k; sel0=sel1=sel2 = codes {0,1,2,3,4,5} -> on the second, o_d0 lane p = 0x0100+p, o_d1 lane p = 0x0200+p, o_wave=2.
- Codes 6 and 7 on accepted data -> the operand is 0xFFFF and 0x0000 respectively; o_sel_err rises one cycle after the code-6 accept and stays high through 3 more clean wavefronts; i_start clears it.
- i_valid low for 3 cycles between accepts, with junk on i_d -> hist unchanged, o_wave unchanged, o_valid=0.
- ena dropped 1 cycle mid-sequence, then re-raised -> next accept gives o_d0 = 0 on all lanes; o_wave continues from its prior value; i_start plus i_valid in the same cycle gives o_wave=1.
- DIAG_AGE=3, accepts A, B, C, D -> o_d0 on D selects lanes of A; CNTW=2 with 5 accepts -> o_wave saturates at 3.

Source files
------------

// File: rtl/dtw_dist_router.sv
// dtw_dist_router: distance-routing stage for the DTW systolic array.
// Keeps a DIAG_AGE-deep history of accepted wavefronts and routes per-PE
// diagonal (D0, from history), vertical (D1) and horizontal (D2, both live)
// operands through per-PE select codes. Code < NPE picks a lane, the all-ones
// code gives zero, anything in between gives INF and raises a sticky error.
// Optional macro DTW_ROUTE_OREG_EN registers the operand and valid outputs.
module dtw_dist_router #(
  parameter int NPE      = 6,
  parameter int DW       = 16,
  parameter int SELW     = 3,
  parameter int DIAG_AGE = 1,
  parameter int CNTW     = 10
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                ena,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [NPE*DW-1:0]   i_d,
  input  logic [NPE*SELW-1:0] i_sel0,
  input  logic [NPE*SELW-1:0] i_sel1,
  input  logic [NPE*SELW-1:0] i_sel2,
  output logic [NPE*DW-1:0]   o_d0,
  output logic [NPE*DW-1:0]   o_d1,
  output logic [NPE*DW-1:0]   o_d2,
  output logic                o_valid,
  output logic [CNTW-1:0]     o_wave,
  output logic                o_sel_err
);

  localparam logic [SELW-1:0] SEL_ZERO = '1;
  localparam logic [CNTW-1:0] WAVE_MAX = '1;

  logic              w_acc;
  logic [NPE*DW-1:0] w_d0;
  logic [NPE*DW-1:0] w_d1;
  logic [NPE*DW-1:0] w_d2;
  logic              w_any_inf;
  logic [NPE*DW-1:0] r_hist [DIAG_AGE];
  logic [CNTW-1:0]   r_wave;
  logic              r_sel_err;

  assign w_acc = ena & i_valid;

  // Lane pick for one select code: lane index, zero code, otherwise INF.
  function automatic logic [DW-1:0] f_decode(input logic [SELW-1:0] c,
                                             input logic [NPE*DW-1:0] v);
    logic [DW-1:0] res;
    res = '1;
    if (c == SEL_ZERO) res = '0;
    for (int l = 0; l < NPE; l++) begin
      if (c == SELW'(l)) res = v[(NPE-1-l)*DW +: DW];
    end
    return res;
  endfunction

  // True when a code falls in the reserved INF range.
  function automatic logic f_is_inf(input logic [SELW-1:0] c);
    logic inf;
    inf = (c != SEL_ZERO);
    for (int l = 0; l < NPE; l++) begin
      if (c == SELW'(l)) inf = 1'b0;
    end
    return inf;
  endfunction

  // Per-PE operand routing and reserved-code detection across all selects.
  always_comb begin
    w_d0      = '0;
    w_d1      = '0;
    w_d2      = '0;
    w_any_inf = 1'b0;
    for (int p = 0; p < NPE; p++) begin
      w_d0[(NPE-1-p)*DW +: DW] = f_decode(i_sel0[(NPE-1-p)*SELW +: SELW], r_hist[DIAG_AGE-1]);
      w_d1[(NPE-1-p)*DW +: DW] = f_decode(i_sel1[(NPE-1-p)*SELW +: SELW], i_d);
      w_d2[(NPE-1-p)*DW +: DW] = f_decode(i_sel2[(NPE-1-p)*SELW +: SELW], i_d);
      w_any_inf = w_any_inf
                | f_is_inf(i_sel0[(NPE-1-p)*SELW +: SELW])
                | f_is_inf(i_sel1[(NPE-1-p)*SELW +: SELW])
                | f_is_inf(i_sel2[(NPE-1-p)*SELW +: SELW]);
    end
  end

  // Wavefront history: cleared by ena low or start, shifted on each accept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < DIAG_AGE; k++) r_hist[k] <= '0;
    end else if (!ena) begin
      for (int k = 0; k < DIAG_AGE; k++) r_hist[k] <= '0;
    end else if (i_start) begin
      for (int k = 0; k < DIAG_AGE; k++) r_hist[k] <= '0;
      if (w_acc) r_hist[0] <= i_d;
    end else if (w_acc) begin
      r_hist[0] <= i_d;
      for (int k = 1; k < DIAG_AGE; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  // Saturating count of accepted wavefronts since the last start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wave <= '0;
    end else if (ena) begin
      if (i_start) begin
        r_wave <= w_acc ? CNTW'(1) : '0;
      end else if (w_acc && (r_wave != WAVE_MAX)) begin
        r_wave <= r_wave + CNTW'(1);
      end
    end
  end

  // Sticky reserved-code flag; start re-arms it, including start-with-data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sel_err <= 1'b0;
    end else if (ena) begin
      if (i_start) begin
        r_sel_err <= w_acc & w_any_inf;
      end else if (w_acc & w_any_inf) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign o_wave    = r_wave;
  assign o_sel_err = r_sel_err;

`ifdef DTW_ROUTE_OREG_EN
  logic [NPE*DW-1:0] r_d0;
  logic [NPE*DW-1:0] r_d1;
  logic [NPE*DW-1:0] r_d2;
  logic              r_valid;

  // Output register stage: operands load on accept and hold otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_d0    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_d0 <= w_d0;
        r_d1 <= w_d1;
        r_d2 <= w_d2;
      end
    end
  end

  assign o_d0    = r_d0;
  assign o_d1    = r_d1;
  assign o_d2    = r_d2;
  assign o_valid = r_valid;
`else
  assign o_d0    = w_d0;
  assign o_d1    = w_d1;
  assign o_d2    = w_d2;
  assign o_valid = w_acc;
`endif

endmodule

// File: tb/tb_dtw_dist_router.sv
// tb_dtw_dist_router: checks two routers side by side on shared stimulus,
// one with default parameters and one with DIAG_AGE=3, CNTW=2, against a
// queue-based model of the accepted wavefronts.
module tb_dtw_dist_router;

  localparam int NPE    = 6;
  localparam int DW     = 16;
  localparam int SELW   = 3;
  localparam int CNTW   = 10;
  localparam int AGE_B  = 3;
  localparam int CNTW_B = 2;
  localparam int VW     = NPE*DW;
  localparam int SW     = NPE*SELW;

  logic            clk = 1'b0;
  logic            nrst;
  logic            ena;
  logic            i_start;
  logic            i_valid;
  logic [VW-1:0]   i_d;
  logic [SW-1:0]   i_sel0;
  logic [SW-1:0]   i_sel1;
  logic [SW-1:0]   i_sel2;

  logic [VW-1:0]   o_d0_a, o_d1_a, o_d2_a;
  logic            o_valid_a, o_sel_err_a;
  logic [CNTW-1:0] o_wave_a;
  logic [VW-1:0]   o_d0_b, o_d1_b, o_d2_b;
  logic            o_valid_b, o_sel_err_b;
  logic [CNTW_B-1:0] o_wave_b;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] mq[$];
  int            mCount = 0;
  bit            mErr   = 1'b0;

  dtw_dist_router #(.NPE(NPE), .DW(DW), .SELW(SELW), .DIAG_AGE(1), .CNTW(CNTW)) u_dut_a (
    .clk(clk), .nrst(nrst), .ena(ena), .i_start(i_start), .i_valid(i_valid),
    .i_d(i_d), .i_sel0(i_sel0), .i_sel1(i_sel1), .i_sel2(i_sel2),
    .o_d0(o_d0_a), .o_d1(o_d1_a), .o_d2(o_d2_a), .o_valid(o_valid_a),
    .o_wave(o_wave_a), .o_sel_err(o_sel_err_a)
  );

  dtw_dist_router #(.NPE(NPE), .DW(DW), .SELW(SELW), .DIAG_AGE(AGE_B), .CNTW(CNTW_B)) u_dut_b (
    .clk(clk), .nrst(nrst), .ena(ena), .i_start(i_start), .i_valid(i_valid),
    .i_d(i_d), .i_sel0(i_sel0), .i_sel1(i_sel1), .i_sel2(i_sel2),
    .o_d0(o_d0_b), .o_d1(o_d1_b), .o_d2(o_d2_b), .o_valid(o_valid_b),
    .o_wave(o_wave_b), .o_sel_err(o_sel_err_b)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] laneOf(logic [VW-1:0] v, int l);
    return v[(NPE-1-l)*DW +: DW];
  endfunction

  function automatic int codeOf(logic [SW-1:0] s, int p);
    return int'(s[(NPE-1-p)*SELW +: SELW]);
  endfunction

  function automatic logic [DW-1:0] refPick(int code, logic [VW-1:0] src);
    if (code < NPE) return laneOf(src, code);
    if (code == (1 << SELW) - 1) return '0;
    return '1;
  endfunction

  function automatic logic [VW-1:0] refRoute(logic [SW-1:0] sel, logic [VW-1:0] src);
    logic [VW-1:0] r;
    r = '0;
    for (int p = 0; p < NPE; p++) r[(NPE-1-p)*DW +: DW] = refPick(codeOf(sel, p), src);
    return r;
  endfunction

  function automatic logic [VW-1:0] histAt(int age);
    if (mq.size() >= age) return mq[mq.size() - age];
    return '0;
  endfunction

  function automatic logic [VW-1:0] seqVec(int base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NPE; k++) v[(NPE-1-k)*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [SW-1:0] packSel(int c0, int c1, int c2, int c3, int c4, int c5);
    logic [SW-1:0] s;
    int c[NPE];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4; c[5] = c5;
    s = '0;
    for (int p = 0; p < NPE; p++) s[(NPE-1-p)*SELW +: SELW] = SELW'(c[p]);
    return s;
  endfunction

  function automatic bit anyInf(logic [SW-1:0] s0, logic [SW-1:0] s1, logic [SW-1:0] s2);
    bit f;
    int c;
    f = 1'b0;
    for (int p = 0; p < NPE; p++) begin
      c = codeOf(s0, p); if (c >= NPE && c != (1 << SELW) - 1) f = 1'b1;
      c = codeOf(s1, p); if (c >= NPE && c != (1 << SELW) - 1) f = 1'b1;
      c = codeOf(s2, p); if (c >= NPE && c != (1 << SELW) - 1) f = 1'b1;
    end
    return f;
  endfunction

  task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(bit e, bit s, bit v, logic [VW-1:0] d,
                               logic [SW-1:0] s0, logic [SW-1:0] s1, logic [SW-1:0] s2);
    ena     = e;
    i_start = s;
    i_valid = v;
    i_d     = d;
    i_sel0  = s0;
    i_sel1  = s1;
    i_sel2  = s2;
  endtask

  task automatic checkOutput();
    logic [VW-1:0] acc;
    logic [VW-1:0] wa;
    logic [VW-1:0] wb;
    acc = VW'(ena & i_valid);
    wa  = VW'((mCount > 1023) ? 1023 : mCount);
    wb  = VW'((mCount > 3) ? 3 : mCount);
    check("valid_a", VW'(o_valid_a), acc);
    check("d0_a", o_d0_a, refRoute(i_sel0, histAt(1)));
    check("d1_a", o_d1_a, refRoute(i_sel1, i_d));
    check("d2_a", o_d2_a, refRoute(i_sel2, i_d));
    check("wave_a", VW'(o_wave_a), wa);
    check("err_a", VW'(o_sel_err_a), VW'(mErr));
    check("valid_b", VW'(o_valid_b), acc);
    check("d0_b", o_d0_b, refRoute(i_sel0, histAt(AGE_B)));
    check("d1_b", o_d1_b, refRoute(i_sel1, i_d));
    check("wave_b", VW'(o_wave_b), wb);
    check("err_b", VW'(o_sel_err_b), VW'(mErr));
  endtask

  // Advance one clock and apply the accepted-wavefront rules to the model.
  task automatic tick();
    bit acc;
    bit inf;
    @(posedge clk);
    #1;
    acc = ena & i_valid;
    inf = anyInf(i_sel0, i_sel1, i_sel2);
    if (!ena) begin
      mq.delete();
    end else if (i_start) begin
      mq.delete();
      mCount = 0;
      mErr   = 1'b0;
      if (acc) begin
        mq.push_back(i_d);
        mCount = 1;
        mErr   = inf;
      end
    end else if (acc) begin
      mq.push_back(i_d);
      mCount++;
      if (inf) mErr = 1'b1;
    end
    while (mq.size() > 4) void'(mq.pop_front());
  endtask

  task automatic step(bit e, bit s, bit v, logic [VW-1:0] d,
                      logic [SW-1:0] s0, logic [SW-1:0] s1, logic [SW-1:0] s2);
    applyStimulus(e, s, v, d, s0, s1, s2);
    #4;
    checkOutput();
    tick();
  endtask

  // Directed sequence followed by a randomized run.
  initial begin
    logic [SW-1:0] idSel;
    logic [SW-1:0] errSel;
    logic [SW-1:0] zeroSel;
    logic [VW-1:0] vA;
    logic [VW-1:0] junk;

    idSel   = packSel(0, 1, 2, 3, 4, 5);
    errSel  = packSel(6, 1, 2, 3, 4, 5);
    zeroSel = packSel(7, 7, 2, 3, 4, 5);

    nrst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, idSel, idSel, idSel);
    #3;
    checkOutput();
    @(posedge clk);
    #1;
    nrst = 1'b1;

    step(1'b1, 1'b0, 1'b0, '0, idSel, idSel, idSel);

    step(1'b1, 1'b0, 1'b1, seqVec(16'h0100), idSel, idSel, idSel);
    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0200), idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_d0_first", o_d0_a, seqVec(16'h0100));
    check("tp_d1_second", o_d1_a, seqVec(16'h0200));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_wave_two", VW'(o_wave_a), VW'(2));
    tick();

    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0300), zeroSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_zero_code", VW'(laneOf(o_d0_a, 0)), VW'(16'h0000));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0400), errSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_inf_code", VW'(laneOf(o_d0_a, 0)), VW'(16'hFFFF));
    check("tp_err_not_yet", VW'(o_sel_err_a), VW'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0500 + 16'h10*i), idSel, idSel, idSel);
      #4;
      checkOutput();
      check("tp_err_sticky", VW'(o_sel_err_a), VW'(1));
      tick();
    end
    step(1'b1, 1'b1, 1'b0, '0, idSel, idSel, idSel);
    step(1'b1, 1'b0, 1'b0, '0, idSel, idSel, idSel);

    step(1'b1, 1'b0, 1'b1, seqVec(16'h0600), idSel, idSel, idSel);
    for (int i = 0; i < 3; i++) begin
      junk = {$urandom(), $urandom(), $urandom()};
      step(1'b1, 1'b0, 1'b0, junk, idSel, idSel, idSel);
    end
    step(1'b1, 1'b0, 1'b1, seqVec(16'h0700), idSel, idSel, idSel);

    step(1'b0, 1'b0, 1'b1, seqVec(16'h0800), idSel, idSel, idSel);
    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0900), idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_d0_after_ena", o_d0_a, '0);
    tick();

    vA = seqVec(16'h0A00);
    step(1'b1, 1'b1, 1'b1, vA, idSel, idSel, idSel);
    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0B00), idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_wave_restart", VW'(o_wave_a), VW'(1));
    tick();
    step(1'b1, 1'b0, 1'b1, seqVec(16'h0C00), idSel, idSel, idSel);
    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0D00), idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_age3_d0", o_d0_b, vA);
    tick();
    step(1'b1, 1'b0, 1'b1, seqVec(16'h0E00), idSel, idSel, idSel);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, idSel, idSel, idSel);
    #4;
    checkOutput();
    check("tp_wave_sat", VW'(o_wave_b), VW'(3));
    tick();

    for (int i = 0; i < 300; i++) begin
      step(($urandom() % 8) != 0, ($urandom() % 16) == 0, ($urandom() % 3) != 0,
           {$urandom(), $urandom(), $urandom()},
           SW'($urandom()), SW'($urandom()), SW'($urandom()));
    end

    applyStimulus(1'b1, 1'b0, 1'b1, seqVec(16'h0F00), idSel, idSel, idSel);
    #2;
    nrst = 1'b0;
    #1;
    mq.delete();
    mCount = 0;
    mErr   = 1'b0;
    checkOutput();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step(1'b1, 1'b0, 1'b1, seqVec(16'h1000), idSel, idSel, idSel);
    step(1'b1, 1'b0, 1'b1, seqVec(16'h1100), idSel, idSel, idSel);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
